// File: rtl/burst_memory_responder.sv
// Line-granular memory model behind the cacheline adapter's 64-bit burst port.
// One read or write at a time: LATENCY wait cycles, four beats, then one idle DONE cycle.
module burst_memory_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [31:0] address_i,
    input  logic [63:0] burst_i,
    output logic [63:0] burst_o,
    output logic        resp_o,
    output logic        err_o
);
    localparam int         DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t                 state;
    logic                   op_write;
    logic [ADDR_BITS-1:0]   idx;
    logic [3:0]             cnt;
    logic [1:0]             beat;
    logic [1:0]             beat_nxt;
    logic                   req_held;
    logic                   opp_req;
    logic [3:0]             we;
    logic [3:0][63:0]       rd_data;
    logic                   unused_addr;

    assign unused_addr = ^{address_i[31:ADDR_BITS+5], address_i[4:0]};
    assign beat_nxt    = beat + 2'd1;
    assign req_held    = op_write ? write_i : read_i;
    assign opp_req     = op_write ? read_i  : write_i;

    // An aborting beat (request already dropped) must not land in memory.
    always_comb begin
        we = '0;
        if (state == BURST && op_write && write_i)
            we[beat] = 1'b1;
    end

    for (genvar k = 0; k < 4; k++) begin : g_bank
        logic [63:0] mem [0:DEPTH-1];
        always_ff @(posedge clk) begin
            if (we[k])
                mem[idx] <= burst_i;
        end
        assign rd_data[k] = mem[idx];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            resp_o   <= 1'b0;
            burst_o  <= '0;
            err_o    <= 1'b0;
            cnt      <= '0;
            beat     <= '0;
            op_write <= 1'b0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_i && write_i) begin
                        err_o <= 1'b1;
                    end else if (read_i || write_i) begin
                        op_write <= write_i;
                        idx      <= address_i[ADDR_BITS+4:5];
                        cnt      <= LAT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!req_held) begin
                        err_o   <= 1'b1;
                        state   <= IDLE;
                        resp_o  <= 1'b0;
                        burst_o <= '0;
                        cnt     <= '0;
                        beat    <= '0;
                    end else begin
                        if (opp_req)
                            err_o <= 1'b1;
                        // Leave WAIT one cycle early so beat 0 comes out of a register.
                        if (cnt == 4'd1) begin
                            state   <= BURST;
                            beat    <= '0;
                            cnt     <= '0;
                            resp_o  <= 1'b1;
                            burst_o <= op_write ? 64'd0 : rd_data[0];
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                BURST: begin
                    if (!req_held) begin
                        err_o   <= 1'b1;
                        state   <= IDLE;
                        resp_o  <= 1'b0;
                        burst_o <= '0;
                        beat    <= '0;
                    end else begin
                        if (opp_req)
                            err_o <= 1'b1;
                        if (beat == 2'd3) begin
                            state   <= DONE;
                            resp_o  <= 1'b0;
                            burst_o <= '0;
                            beat    <= '0;
                        end else begin
                            beat    <= beat_nxt;
                            burst_o <= op_write ? 64'd0 : rd_data[beat_nxt];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_burst_memory_responder.sv
// Self-checking bench for burst_memory_responder: reference line model plus a beat scoreboard.
module tb_burst_memory_responder;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        read_i;
    logic        write_i;
    logic [31:0] address_i;
    logic [63:0] burst_i;
    logic [63:0] burst_o;
    logic        resp_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    logic [3:0][63:0] model_mem [int];
    logic [63:0]      exp_q [$];

    burst_memory_responder #(.ADDR_BITS(10), .LATENCY(L)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .read_i    (read_i),
        .write_i   (write_i),
        .address_i (address_i),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .resp_o    (resp_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int line_of(input logic [31:0] a);
        return int'(a[14:5]);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full write transaction with resp timing checks; beats advance after each seen resp.
    task automatic write_line(input logic [31:0] addr, input logic [3:0][63:0] w, input string tag);
        int nb = 0;
        model_mem[line_of(addr)] = w;
        address_i = addr;
        write_i   = 1'b1;
        burst_i   = w[0];
        for (int k = 0; k <= L + 5; k++) begin
            logic exp_resp;
            @(negedge clk);
            exp_resp = (k >= L + 1) && (k <= L + 4);
            checks++;
            if (resp_o !== exp_resp) begin
                errors++;
                $display("FAIL %s_resp cycle %0d: got %b want %b", tag, k, resp_o, exp_resp);
            end
            if (resp_o === 1'b1) nb++;
            next_cycle();
            if (nb < 4) burst_i = w[nb];
            if (k == L + 4) write_i = 1'b0;
        end
    endtask

    // Full read transaction; expected beats come from the model through the scoreboard queue.
    task automatic read_line(input logic [31:0] addr, input string tag);
        logic [3:0][63:0] line = model_mem.exists(line_of(addr)) ? model_mem[line_of(addr)] : '0;
        for (int b = 0; b < 4; b++) exp_q.push_back(line[b]);
        address_i = addr;
        read_i    = 1'b1;
        for (int k = 0; k <= L + 5; k++) begin
            logic exp_resp;
            @(negedge clk);
            exp_resp = (k >= L + 1) && (k <= L + 4);
            checks++;
            if (resp_o !== exp_resp) begin
                errors++;
                $display("FAIL %s_resp cycle %0d: got %b want %b", tag, k, resp_o, exp_resp);
            end
            if (resp_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra_beat cycle %0d: got %h want none", tag, k, burst_o);
                end else begin
                    logic [63:0] e = exp_q.pop_front();
                    checks++;
                    if (burst_o !== e) begin
                        errors++;
                        $display("FAIL %s_data cycle %0d: got %h want %h", tag, k, burst_o, e);
                    end
                end
            end else begin
                checks++;
                if (burst_o !== 64'd0) begin
                    errors++;
                    $display("FAIL %s_idle_data cycle %0d: got %h want 0", tag, k, burst_o);
                end
            end
            next_cycle();
            if (k == L + 4) read_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; read_i = 1'b1; write_i = 1'b0; address_i = '0; burst_i = '0;
        repeat (2) next_cycle();
        checks += 3;
        if (resp_o !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b want 0", resp_o); end
        if (burst_o !== 64'd0) begin errors++; $display("FAIL reset_burst: got %h want 0", burst_o); end
        if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
        reset_n = 1'b1; read_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (resp_o !== 1'b0) begin errors++; $display("FAIL reset_quiet cycle %0d: got %b want 0", k, resp_o); end
            next_cycle();
        end
    endtask

    task automatic test_write_read();
        logic [3:0][63:0] w;
        w[0] = 64'h1111_1111_1111_1111; w[1] = 64'h2222_2222_2222_2222;
        w[2] = 64'h3333_3333_3333_3333; w[3] = 64'h4444_4444_4444_4444;
        write_line(32'h0000_0040, w, "wr40");
        read_line(32'h0000_0040, "rd40");
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL wr_rd_err: got %b want 0", err_o); end
    endtask

    task automatic test_offset_ignored();
        read_line(32'h0000_005C, "rd5c");
    endtask

    task automatic test_back_to_back();
        logic [3:0][63:0] line = model_mem[line_of(32'h40)];
        for (int r = 0; r < 2; r++)
            for (int b = 0; b < 4; b++) exp_q.push_back(line[b]);
        address_i = 32'h40;
        read_i    = 1'b1;
        for (int k = 0; k <= 2 * L + 11; k++) begin
            logic exp_resp;
            @(negedge clk);
            exp_resp = ((k >= L + 1) && (k <= L + 4)) || ((k >= 2 * L + 7) && (k <= 2 * L + 10));
            checks++;
            if (resp_o !== exp_resp) begin
                errors++;
                $display("FAIL b2b_resp cycle %0d: got %b want %b", k, resp_o, exp_resp);
            end
            if (resp_o === 1'b1 && exp_q.size() != 0) begin
                logic [63:0] e = exp_q.pop_front();
                checks++;
                if (burst_o !== e) begin
                    errors++;
                    $display("FAIL b2b_data cycle %0d: got %h want %h", k, burst_o, e);
                end
            end
            next_cycle();
            if (k == 2 * L + 10) read_i = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_beats_left: got %0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_conflict();
        read_i = 1'b1; write_i = 1'b1; address_i = 32'h40;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks += 2;
            if (resp_o !== 1'b0) begin errors++; $display("FAIL conflict_resp cycle %0d: got %b want 0", k, resp_o); end
            if (err_o !== (k >= 1)) begin errors++; $display("FAIL conflict_err cycle %0d: got %b want %b", k, err_o, k >= 1); end
            next_cycle();
        end
        read_i = 1'b0; write_i = 1'b0;
        // Normal read latency afterwards shows the block never left IDLE.
        read_line(32'h40, "post_conflict");
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL conflict_sticky: got %b want 1", err_o); end
    endtask

    task automatic test_abort();
        logic [3:0][63:0] a;
        logic [3:0][63:0] m;
        int nb = 0;
        a[0] = 64'hA0A0_0000_0000_00A0; a[1] = 64'hA1A1_0000_0000_00A1;
        a[2] = 64'hA2A2_0000_0000_00A2; a[3] = 64'hA3A3_0000_0000_00A3;
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        write_line(32'h80, '0, "zero80");
        m = '0; m[0] = a[0]; m[1] = a[1];
        model_mem[line_of(32'h80)] = m;
        address_i = 32'h80; write_i = 1'b1; burst_i = a[0];
        for (int k = 0; k <= L + 5; k++) begin
            logic exp_resp;
            logic exp_err;
            @(negedge clk);
            exp_resp = (k >= L + 1) && (k <= L + 3);
            exp_err  = (k >= L + 4);
            checks += 2;
            if (resp_o !== exp_resp) begin errors++; $display("FAIL abort_resp cycle %0d: got %b want %b", k, resp_o, exp_resp); end
            if (err_o !== exp_err) begin errors++; $display("FAIL abort_err cycle %0d: got %b want %b", k, err_o, exp_err); end
            if (resp_o === 1'b1) nb++;
            next_cycle();
            if (nb < 4) burst_i = a[nb];
            if (nb == 2) write_i = 1'b0;
        end
        read_line(32'h80, "rd80_abort");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_offset_ignored();
        test_back_to_back();
        test_conflict();
        test_abort();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d beats left want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
